mem2wb_bridge: RTL
==================

# mem2wb_bridge

Bridges the PicoRV32 native memory interface to a classic Wishbone B4 initiator port, so that CPU accesses decoded by `simple_interconnect` can reach Wishbone responders such as `user_proj_example`. It is the initiator counterpart of the wrapper's Wishbone responder port. Each CPU access becomes one single Wishbone cycle, with a bounded wait and error reporting. The block sits beside `spimemio` and `simpleuart` as another responder of the interconnect and runs in the CPU clock domain.

## Interface
- `TIMEOUT`, 255: number of cycles in WAIT without `wbm_ack_i`/`wbm_err_i` before the bridge aborts the cycle; range 1..255.
- `clk` in 1: CPU clock (io_in[8] at top level).
- `resetn` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: access request, already address-decoded by the interconnect; held high until the cycle after `wb_ready`.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write strobes; 0 means read.
- `wb_ready` out 1: one-cycle completion pulse to the interconnect.
- `wb_rdata` out 32: read data, valid while `wb_ready` is high.
- `wbm_cyc_o`, `wbm_stb_o` out 1: Wishbone cycle and strobe; always equal.
- `wbm_we_o` out 1: write enable.
- `wbm_sel_o` out 4: byte selects.
- `wbm_adr_o` out 32: word address, {mem_addr[31:2], 2'b00}.
- `wbm_dat_o` out 32: write data.
- `wbm_dat_i` in 32: read data.
- `wbm_ack_i` in 1: responder acknowledge.
- `wbm_err_i` in 1: responder error.
- `bus_err_o` out 1: one-cycle pulse on an error or timeout completion.
- `err_count_o` out 8: saturating count of error and timeout completions.

## Operation
- All state and outputs are registered.
- Reset values: every output is 0, the FSM is in IDLE, and the timeout counter is 0.
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - Moves to WAIT when `wb_valid & ~wb_ready`.
  - On that transition it latches the address, data, `we = |mem_wstrb` and `sel = we ? mem_wstrb : 4'hF`, sets cyc/stb to 1 and clears the counter.
- WAIT: cyc/stb stay high and all Wishbone outputs stay stable. Each cycle is evaluated in this priority order:
  - `wbm_err_i`: error completion.
  - else `wbm_ack_i`: normal completion.
  - else counter == TIMEOUT-1: timeout completion.
  - else: the counter increments.
- Any completion clears cyc/stb and moves the FSM to RESP.
- `wb_rdata` on completion:
  - Read ack: `wbm_dat_i`.
  - Write ack: 0.
  - Error or timeout: 32'hFFFF_FFFF.
- On error or timeout, `bus_err_o` is 1 and `err_count_o` increments, saturating at 255.
- RESP: `wb_ready` is 1 for exactly this cycle. The FSM returns to IDLE unconditionally.
- `wb_rdata` holds its value until the next completion.
- `wbm_we_o`, `wbm_sel_o` and `wbm_adr_o` may keep stale values while cyc is low. `wbm_dat_o` is held as well.
- Responses arriving outside WAIT (`wbm_ack_i`/`wbm_err_i` while cyc is low) are ignored.
- Reset mid-cycle: cyc/stb drop asynchronously and no `wb_ready` is issued.

## Timing
- Request accepted at edge N → cyc/stb high starting in cycle N+1.
- Ack sampled at edge M → cyc/stb low and `wb_ready` high in cycle M+1.
- Minimum latency: 2 cycles from `wb_valid` to `wb_ready`, with a zero-wait responder that acks in the first stb cycle.
- Timeout: the cycle ends after exactly TIMEOUT stb cycles, and `wb_ready` follows in the next cycle.
- No back-to-back cycles: at least one idle cycle (RESP) separates consecutive cyc assertions.
- `bus_err_o` rises in the same cycle as `wb_ready`.

## Test plan
- Read with ack in the first stb cycle, `wbm_dat_i=32'hDEADBEEF`:
  - cyc high for exactly 1 cycle, `we=0`, `sel=4'hF`.
  - `wb_ready` 2 cycles after valid, with `wb_rdata=32'hDEADBEEF`.
- Byte write, `mem_addr=32'h3000_0006`, `wstrb=4'b0100`, ack after 3 wait cycles:
  - `adr=32'h3000_0004`, `sel=4'b0100`, `we=1`.
  - `wb_ready` 1 cycle after ack, `bus_err_o=0`.
- Responder never answers, TIMEOUT=4:
  - cyc high 4 cycles.
  - `wb_ready` and `bus_err_o` both pulse, `rdata=32'hFFFF_FFFF`.
  - `err_count_o=1`.
- Ack and err asserted in the same cycle:
  - Completion is treated as an error: `rdata=32'hFFFF_FFFF`, `err_count_o` increments.
- Reset pulse in the 2nd WAIT cycle:
  - cyc/stb drop asynchronously and all outputs read 0.
  - After release, a new read completes normally.
- 260 consecutive err completions:
  - `err_count_o` saturates at 255.
  - Spurious `wbm_ack_i` pulses while IDLE have no effect.

Source files
------------

// File: rtl/mem2wb_bridge.sv
// PicoRV32 native memory port to classic Wishbone B4 initiator bridge.
// One Wishbone cycle per CPU access, with bounded wait and saturating error counting.
module mem2wb_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        wb_ready,
    output logic [31:0] wb_rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        bus_err_o,
    output logic [7:0]  err_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST_CNT = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_cyc;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_bus_err;
    logic [7:0]  r_err_count;

    logic w_req_we;
    logic w_timeout;
    logic w_done;
    logic w_fail;

    assign w_req_we  = |mem_wstrb;
    assign w_timeout = (r_cnt == LP_LAST_CNT);
    assign w_done    = wbm_err_i | wbm_ack_i | w_timeout;
    // An ack beats a simultaneous timeout, but an err beats an ack.
    assign w_fail    = wbm_err_i | (~wbm_ack_i & w_timeout);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'd0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_ready     <= 1'b0;
            r_rdata     <= 32'd0;
            r_bus_err   <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_ready   <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_valid && !r_ready) begin
                        r_adr   <= mem_addr & 32'hFFFF_FFFC;
                        r_dat   <= mem_wdata;
                        r_we    <= w_req_we;
                        r_sel   <= w_req_we ? mem_wstrb : 4'hF;
                        r_cyc   <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_cyc   <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                        if (w_fail) begin
                            r_rdata   <= 32'hFFFF_FFFF;
                            r_bus_err <= 1'b1;
                            if (r_err_count != 8'hFF)
                                r_err_count <= r_err_count + 8'd1;
                        end else begin
                            r_rdata <= r_we ? 32'd0 : wbm_dat_i;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_ready    = r_ready;
    assign wb_rdata    = r_rdata;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign bus_err_o   = r_bus_err;
    assign err_count_o = r_err_count;

endmodule
